// File: rtl/m_wb_uart_pkg.sv
// Shared definitions for the Wishbone UART: register word offsets, STATUS bit
// positions, default divisor and FSM state encodings.
package m_wb_uart_pkg;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_DIV    = 2'd2;
    localparam logic [1:0] ADR_RSVD   = 2'd3;

    localparam int ST_TXBUSY  = 0;
    localparam int ST_RXVALID = 1;
    localparam int ST_OVERRUN = 2;
    localparam int ST_FERR    = 3;

    localparam int UART_DIVISOR_DEFAULT = 104;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/m_uart_baudcnt.sv
// Down-counter pacing one bit period; tick_o marks count 0 and the counter
// reloads from div_i there, so a changed divisor takes effect at the next bit.
module m_uart_baudcnt #(
    parameter int DIVWIDTH = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [DIVWIDTH-1:0] load_val_i,
    input  logic [DIVWIDTH-1:0] div_i,
    output logic                tick_o
);

    logic [DIVWIDTH-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - DIVWIDTH'(1);
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_o) begin
            cnt_d = div_i - DIVWIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/m_wb_uart.sv
// Wishbone-classic responder with an 8N1 UART (TX + RX) for midgetv: DATA,
// STATUS and DIV registers replace bit-banging of usartTX / sampling of usartRX.
module m_wb_uart
    import m_wb_uart_pkg::*;
#(
    parameter int DIVISOR_DEFAULT = UART_DIVISOR_DEFAULT,
    parameter int DIVWIDTH        = 16
) (
    input  logic        CLK_I,
    input  logic        RSTn_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [1:0]  ADR_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    input  logic        usartRX,
    output logic        usartTX
);

    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d, rdata;
    logic [DIVWIDTH-1:0] div_q, div_d, div_eff;
    logic                access, data_wr, data_rd, status_wr, div_wr;
    logic                unused_dat;

    tx_state_e           tx_state_q, tx_state_d;
    logic [7:0]          tx_shift_q, tx_shift_d;
    logic [2:0]          tx_bit_q, tx_bit_d;
    logic                tx_q, tx_d, tx_load, tx_tick, txbusy;

    rx_state_e           rx_state_q, rx_state_d;
    logic                rx_s1_q, rx_s2_q, rx_prev_q;
    logic [7:0]          rx_shift_q, rx_shift_d, rxbyte_q, rxbyte_d;
    logic [2:0]          rx_bit_q, rx_bit_d;
    logic                rxvalid_q, rxvalid_d, overrun_q, overrun_d, ferr_q, ferr_d;
    logic                rx_load, rx_tick, rx_done;

    assign unused_dat = ^DAT_I[31:DIVWIDTH];

    assign access    = CYC_I & STB_I & ~ack_q;
    assign data_wr   = access &  WE_I & (ADR_I == ADR_DATA);
    assign data_rd   = access & ~WE_I & (ADR_I == ADR_DATA);
    assign status_wr = access &  WE_I & (ADR_I == ADR_STATUS);
    assign div_wr    = access &  WE_I & (ADR_I == ADR_DIV);

    // Divisors below 2 would leave no room for a half-bit start wait.
    assign div_eff = (div_q < DIVWIDTH'(2)) ? DIVWIDTH'(2) : div_q;
    assign txbusy  = (tx_state_q != TX_IDLE);

    always_comb begin
        rdata = '0;
        case (ADR_I)
            ADR_DATA:   rdata[7:0]          = rxbyte_q;
            ADR_STATUS: rdata[3:0]          = {ferr_q, overrun_q, rxvalid_q, txbusy};
            ADR_DIV:    rdata[DIVWIDTH-1:0] = div_q;
            default:    rdata = '0;
        endcase
    end

    assign ack_d = access;
    assign dat_d = (access & ~WE_I) ? rdata : '0;
    assign div_d = div_wr ? DAT_I[DIVWIDTH-1:0] : div_q;

    m_uart_baudcnt #(.DIVWIDTH(DIVWIDTH)) u_tx_baud (
        .clk_i      (CLK_I),
        .rst_ni     (RSTn_I),
        .load_i     (tx_load),
        .load_val_i (div_eff - DIVWIDTH'(1)),
        .div_i      (div_eff),
        .tick_o     (tx_tick)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (data_wr) begin
                    tx_load    = 1'b1;
                    tx_shift_d = DAT_I[7:0];
                    tx_d       = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[7:1]};
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_tick) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX start wait is half a bit so later samples land mid-bit.
    m_uart_baudcnt #(.DIVWIDTH(DIVWIDTH)) u_rx_baud (
        .clk_i      (CLK_I),
        .rst_ni     (RSTn_I),
        .load_i     (rx_load),
        .load_val_i ((div_eff >> 1) - DIVWIDTH'(1)),
        .div_i      (div_eff),
        .tick_o     (rx_tick)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_load    = 1'b0;
        rx_done    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_load    = 1'b1;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_done    = 1'b1;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // A read coinciding with completion returns the old byte and keeps rxvalid set.
    always_comb begin
        rxbyte_d  = rxbyte_q;
        rxvalid_d = rxvalid_q;
        overrun_d = overrun_q;
        ferr_d    = ferr_q;
        if (data_rd) rxvalid_d = 1'b0;
        if (status_wr) begin
            if (DAT_I[ST_OVERRUN]) overrun_d = 1'b0;
            if (DAT_I[ST_FERR])    ferr_d    = 1'b0;
        end
        if (rx_done) begin
            if (!rx_s2_q) ferr_d = 1'b1;
            if (rxvalid_q && !data_rd) begin
                overrun_d = 1'b1;
            end else begin
                rxbyte_d  = rx_shift_q;
                rxvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RSTn_I) begin
        if (!RSTn_I) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            div_q      <= DIVWIDTH'(DIVISOR_DEFAULT);
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rxbyte_q   <= '0;
            rxvalid_q  <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            div_q      <= div_d;
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            rx_s1_q    <= usartRX;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rxbyte_q   <= rxbyte_d;
            rxvalid_q  <= rxvalid_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
        end
    end

    assign ACK_O   = ack_q;
    assign DAT_O   = dat_q;
    assign usartTX = tx_q;

endmodule

// File: tb/tb_m_wb_uart.sv
// Directed-plus-random bench for m_wb_uart: bus protocol, TX line shape,
// RX reception with overrun/framing flags against a behavioural model.
`timescale 1ns/1ps
module tb_m_wb_uart;

    localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_DIV = 2'd2, A_RSVD = 2'd3;

    logic        CLK_I = 1'b0;
    logic        RSTn_I = 1'b0;
    logic        CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
    logic [1:0]  ADR_I = 2'd0;
    logic [31:0] DAT_I = 32'h0;
    logic [31:0] DAT_O;
    logic        ACK_O;
    logic        usartRX = 1'b1;
    logic        usartTX;

    int checks = 0;
    int failures = 0;

    m_wb_uart #(.DIVISOR_DEFAULT(104), .DIVWIDTH(16)) dut (
        .CLK_I   (CLK_I),
        .RSTn_I  (RSTn_I),
        .CYC_I   (CYC_I),
        .STB_I   (STB_I),
        .WE_I    (WE_I),
        .ADR_I   (ADR_I),
        .DAT_I   (DAT_I),
        .DAT_O   (DAT_O),
        .ACK_O   (ACK_O),
        .usartRX (usartRX),
        .usartTX (usartTX)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge; one access cycle, one ACK cycle, one idle cycle.
    task automatic wb(input logic we, input logic [1:0] adr, input logic [31:0] wd,
                      output logic [31:0] rd);
        int n;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wd;
        n = 0;
        do begin
            @(posedge CLK_I);
            @(negedge CLK_I);
            n++;
        end while (!ACK_O && n < 8);
        chk("ack_latency", ACK_O ? n : 0, 32'd1);
        rd = DAT_O;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        @(negedge CLK_I);
        chk("ack_one_cycle", {31'b0, ACK_O}, 32'd0);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] wd);
        logic [31:0] dummy;
        wb(1'b1, adr, wd, dummy);
    endtask

    task automatic rd(input logic [1:0] adr, output logic [31:0] d);
        wb(1'b0, adr, 32'h0, d);
    endtask

    // Expected line: start 0, eight data bits LSB first, stop 1, each d clocks.
    task automatic tx_frame(input logic [7:0] b, input int d, input bit poke);
        int  seg;
        int  j;
        logic expbit;
        wr(A_DATA, {24'h0, b});
        j = 1;
        while (j < 10 * d) begin
            seg = j / d;
            if (seg == 0)      expbit = 1'b0;
            else if (seg == 9) expbit = 1'b1;
            else               expbit = b[seg-1];
            chk("tx_bit", {31'b0, usartTX}, {31'b0, expbit});
            if (poke && j == 2 * d + 1) begin
                wr(A_DATA, {24'h0, ~b});
                j += 2;
            end else begin
                @(negedge CLK_I);
                j++;
            end
        end
        repeat (2 * d) begin
            chk("tx_idle", {31'b0, usartTX}, 32'd1);
            @(negedge CLK_I);
        end
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stopb, input int d);
        usartRX = 1'b0;
        repeat (d) @(negedge CLK_I);
        for (int i = 0; i < 8; i++) begin
            usartRX = b[i];
            repeat (d) @(negedge CLK_I);
        end
        usartRX = stopb;
        repeat (d) @(negedge CLK_I);
        usartRX = 1'b1;
        repeat (2 * d + 4) @(negedge CLK_I);
    endtask

    initial begin
        logic [31:0] s;
        logic [7:0]  b, fb;
        logic        sb;
        logic        m_valid, m_ovr, m_ferr;
        logic [7:0]  m_byte;

        repeat (3) @(negedge CLK_I);
        chk("rst_tx", {31'b0, usartTX}, 32'd1);
        chk("rst_ack", {31'b0, ACK_O}, 32'd0);
        chk("rst_dat", DAT_O, 32'd0);
        RSTn_I = 1'b1;
        @(negedge CLK_I);

        rd(A_STATUS, s);  chk("rst_status", s, 32'h0);
        chk("rst_tx_after", {31'b0, usartTX}, 32'd1);
        rd(A_DIV, s);     chk("div_default", s, 32'd104);

        wr(A_DIV, 32'hFFFF_0007);
        rd(A_DIV, s);     chk("div_upper_zero", s, 32'h7);
        wr(A_RSVD, 32'hDEAD_BEEF);
        rd(A_RSVD, s);    chk("rsvd_read", s, 32'h0);
        rd(A_DIV, s);     chk("rsvd_no_effect", s, 32'h7);
        wr(A_DIV, 32'h0);
        rd(A_DIV, s);     chk("div_zero_read", s, 32'h0);
        tx_frame(8'($urandom), 2, 1'b0);

        wr(A_DIV, 32'd4);
        tx_frame(8'h55, 4, 1'b1);
        tx_frame(8'($urandom), 4, 1'b0);

        wr(A_DATA, 32'h0000_00F0);
        repeat (38) @(negedge CLK_I);
        rd(A_STATUS, s);  chk("txbusy_last_cycle", s, 32'h1);
        repeat (2) @(negedge CLK_I);
        wr(A_DATA, 32'h0000_000F);
        repeat (39) @(negedge CLK_I);
        rd(A_STATUS, s);  chk("txbusy_released", s, 32'h0);

        rx_send(8'hA3, 1'b1, 4);
        rd(A_STATUS, s);  chk("rx_status_valid", s, 32'h2);
        rd(A_DATA, s);    chk("rx_data", s, 32'h0000_00A3);
        rd(A_STATUS, s);  chk("rx_status_clear", s, 32'h0);

        rx_send(8'h11, 1'b1, 4);
        rx_send(8'h22, 1'b1, 4);
        rd(A_STATUS, s);  chk("ovr_status", s, 32'h6);
        rd(A_DATA, s);    chk("ovr_keeps_old", s, 32'h11);
        rd(A_STATUS, s);  chk("ovr_sticky", s, 32'h4);
        wr(A_STATUS, 32'h4);
        rd(A_STATUS, s);  chk("ovr_cleared", s, 32'h0);

        fb = 8'($urandom);
        rx_send(fb, 1'b0, 4);
        rd(A_STATUS, s);  chk("ferr_status", s, 32'hA);
        rd(A_DATA, s);    chk("ferr_byte", s, {24'h0, fb});
        rd(A_STATUS, s);  chk("ferr_sticky", s, 32'h8);
        wr(A_STATUS, 32'h8);
        rd(A_STATUS, s);  chk("ferr_cleared", s, 32'h0);

        usartRX = 1'b0;
        repeat (2) @(negedge CLK_I);
        usartRX = 1'b1;
        repeat (60) @(negedge CLK_I);
        rd(A_STATUS, s);  chk("glitch_ignored", s, 32'h0);
        rd(A_DATA, s);    chk("glitch_byte", s, {24'h0, fb});

        m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_byte = fb;
        for (int i = 0; i < 6; i++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            rx_send(b, sb, 4);
            if (!sb) m_ferr = 1'b1;
            if (m_valid) m_ovr = 1'b1;
            else begin
                m_byte  = b;
                m_valid = 1'b1;
            end
            rd(A_STATUS, s);
            chk("rnd_status", s, {28'h0, m_ferr, m_ovr, m_valid, 1'b0});
            if ($urandom_range(0, 1) == 1) begin
                rd(A_DATA, s);
                chk("rnd_data", s, {24'h0, m_byte});
                m_valid = 1'b0;
            end
            if (i == 2 || i == 4) begin
                wr(A_STATUS, 32'hC);
                m_ovr  = 1'b0;
                m_ferr = 1'b0;
            end
        end

        wr(A_DATA, 32'h0);
        repeat (3) @(negedge CLK_I);
        chk("midtx_low", {31'b0, usartTX}, 32'd0);
        #2 RSTn_I = 1'b0;
        #1 chk("async_reset_tx", {31'b0, usartTX}, 32'd1);
        @(negedge CLK_I);
        RSTn_I = 1'b1;
        repeat (3) @(negedge CLK_I);
        chk("post_reset_tx", {31'b0, usartTX}, 32'd1);
        rd(A_STATUS, s);  chk("post_reset_status", s, 32'h0);
        rd(A_DIV, s);     chk("post_reset_div", s, 32'd104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
